// File: rtl/sirv_pwm16_icb_arb.sv
// Two-master ICB arbiter in front of the shared PWM16 slave: one outstanding
// transaction, round-robin on ties, combinational forwarding while idle.
module sirv_pwm16_icb_arb #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clock,
    input  logic          reset,

    input  logic          m0_icb_cmd_valid,
    input  logic          m0_icb_cmd_read,
    input  logic [AW-1:0] m0_icb_cmd_addr,
    input  logic [DW-1:0] m0_icb_cmd_wdata,
    output logic          m0_icb_cmd_ready,
    output logic          m0_icb_rsp_valid,
    output logic [DW-1:0] m0_icb_rsp_rdata,
    input  logic          m0_icb_rsp_ready,

    input  logic          m1_icb_cmd_valid,
    input  logic          m1_icb_cmd_read,
    input  logic [AW-1:0] m1_icb_cmd_addr,
    input  logic [DW-1:0] m1_icb_cmd_wdata,
    output logic          m1_icb_cmd_ready,
    output logic          m1_icb_rsp_valid,
    output logic [DW-1:0] m1_icb_rsp_rdata,
    input  logic          m1_icb_rsp_ready,

    output logic          o_icb_cmd_valid,
    output logic          o_icb_cmd_read,
    output logic [AW-1:0] o_icb_cmd_addr,
    output logic [DW-1:0] o_icb_cmd_wdata,
    input  logic          o_icb_cmd_ready,
    input  logic          o_icb_rsp_valid,
    input  logic [DW-1:0] o_icb_rsp_rdata,
    output logic          o_icb_rsp_ready,

    output logic          arb_busy,
    output logic          arb_owner
);

    typedef enum logic [1:0] {IDLE, CMD, RSP} state_t;

    state_t state;
    logic   owner;
    logic   prio;
    logic   busy;

    logic   winner;
    logic   sel;
    logic   cmd_path;
    logic   rsp_path;

    always_comb begin
        winner   = (m0_icb_cmd_valid && m1_icb_cmd_valid) ? prio : m1_icb_cmd_valid;
        sel      = (state == IDLE) ? winner : owner;
        cmd_path = (state != RSP);
        rsp_path = (state == RSP);

        o_icb_cmd_valid = cmd_path && (sel ? m1_icb_cmd_valid : m0_icb_cmd_valid);
        o_icb_cmd_read  = '0;
        o_icb_cmd_addr  = '0;
        o_icb_cmd_wdata = '0;
        if (o_icb_cmd_valid) begin
            o_icb_cmd_read  = sel ? m1_icb_cmd_read  : m0_icb_cmd_read;
            o_icb_cmd_addr  = sel ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
            o_icb_cmd_wdata = sel ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
        end
        m0_icb_cmd_ready = o_icb_cmd_valid && !sel && o_icb_cmd_ready;
        m1_icb_cmd_ready = o_icb_cmd_valid &&  sel && o_icb_cmd_ready;

        // Responses reach a master only while its transaction is in RSP
        o_icb_rsp_ready  = rsp_path && (owner ? m1_icb_rsp_ready : m0_icb_rsp_ready);
        m0_icb_rsp_valid = rsp_path && !owner && o_icb_rsp_valid;
        m1_icb_rsp_valid = rsp_path &&  owner && o_icb_rsp_valid;
        m0_icb_rsp_rdata = (rsp_path && !owner) ? o_icb_rsp_rdata : '0;
        m1_icb_rsp_rdata = (rsp_path &&  owner) ? o_icb_rsp_rdata : '0;

        arb_busy  = busy;
        arb_owner = owner;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            owner <= 1'b0;
            prio  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (o_icb_cmd_valid) begin
                        owner <= winner;
                        busy  <= 1'b1;
                        if (o_icb_cmd_ready) begin
                            state <= RSP;
                            prio  <= ~winner;
                        end else begin
                            state <= CMD;
                        end
                    end
                end
                CMD: begin
                    if (o_icb_cmd_valid && o_icb_cmd_ready) begin
                        state <= RSP;
                        prio  <= ~owner;
                    end
                end
                RSP: begin
                    if (o_icb_rsp_valid && o_icb_rsp_ready) begin
                        state <= IDLE;
                        owner <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    owner <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
